// File: rtl/mem_pkg.sv
// Shared memory-path definitions: funct3 codes, RAM command encodings, LSU FSM states
// and request legality helpers used by the LSU, the RAM and the CPU memory stage.
package mem_pkg;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // RAM command encodings
    localparam logic [2:0] RAM_READ_WORD  = 3'b001;
    localparam logic [2:0] RAM_READ_IDLE  = 3'b000;
    localparam logic [1:0] RAM_WRITE_WORD = 2'b01;
    localparam logic [1:0] RAM_WRITE_IDLE = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_e;

    function automatic logic funct3_illegal(input logic is_store, input logic [2:0] funct3);
        logic bad;
        if (is_store) begin
            case (funct3)
                F3_SB, F3_SH, F3_SW: bad = 1'b0;
                default:             bad = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: bad = 1'b0;
                default:                             bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    // funct3[1:0] carries the access size for every legal code
    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic req_error(input logic is_store, input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        return funct3_illegal(is_store, funct3) | addr_misaligned(funct3, addr_lo);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake between the CPU memory stage and the LSU, plus the
// word-wide RAM port. master = CPU/RAM environment side, slave = the LSU.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] ram_address;
    logic [31:0] ram_data_in;
    logic [1:0]  ram_mem_write;
    logic [2:0]  ram_mem_read;
    logic [31:0] ram_data_out;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, ram_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               ram_address, ram_data_in, ram_mem_write, ram_mem_read
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, ram_data_out,
        output req_ready, resp_valid, resp_rdata, resp_error,
               ram_address, ram_data_in, ram_mem_write, ram_mem_read
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte/half lane steering: load extraction with sign/zero extension, and the
// store merge used for the write half of a sub-word read-modify-write.
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] lo,
                                                 input logic [2:0] f3);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        case (lo)
            2'b00:   byte_v = word[7:0];
            2'b01:   byte_v = word[15:8];
            2'b10:   byte_v = word[23:16];
            2'b11:   byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   res = {{24{byte_v[7]}}, byte_v};
            F3_LBU:  res = {24'd0, byte_v};
            F3_LH:   res = {{16{half_v[15]}}, half_v};
            F3_LHU:  res = {16'd0, half_v};
            F3_LW:   res = word;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] old_word, input logic [31:0] wd,
                                                input logic [1:0] lo, input logic [2:0] f3);
        logic [31:0] res;
        res = old_word;
        case (f3)
            F3_SB: begin
                case (lo)
                    2'b00:   res[7:0]   = wd[7:0];
                    2'b01:   res[15:8]  = wd[7:0];
                    2'b10:   res[23:16] = wd[7:0];
                    2'b11:   res[31:24] = wd[7:0];
                    default: res[7:0]   = wd[7:0];
                endcase
            end
            F3_SH: begin
                if (lo[1]) begin
                    res[31:16] = wd[15:0];
                end else begin
                    res[15:0] = wd[15:0];
                end
            end
            F3_SW:   res = wd;
            default: res = old_word;
        endcase
        return res;
    endfunction

    // Both lane paths are pure functions of the captured request and the RAM word
    always_comb begin
        load_data  = extract_load(word_in, addr_lo, funct3);
        store_word = merge_store(word_in, wdata, addr_lo, funct3);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request in flight, alignment/funct3 checking, word-wide RAM
// accesses with read-modify-write for SB/SH, and one registered response per request.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int RAM_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);

    localparam logic [1:0] WAIT_LAST = 2'(RAM_LATENCY - 1);

    lsu_state_e  state_r;
    lsu_state_e  state_nxt_s;
    logic        accept_s;
    logic        req_err_s;
    logic        is_sw_s;
    logic        wait_done_s;
    logic [31:0] align_word_s;
    logic [31:0] load_data_s;
    logic [31:0] store_word_s;

    logic        write_r;
    logic [2:0]  funct3_r;
    logic [1:0]  addr_lo_r;
    logic [31:0] wdata_r;
    logic [31:0] rd_word_r;
    logic [1:0]  wait_cnt_r;

    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic        resp_error_r;
    logic [31:0] ram_address_r;
    logic [31:0] ram_data_in_r;
    logic [1:0]  ram_mem_write_r;
    logic [2:0]  ram_mem_read_r;

    assign bus.req_ready     = (state_r == ST_IDLE) && !reset;
    assign bus.resp_valid    = resp_valid_r;
    assign bus.resp_rdata    = resp_rdata_r;
    assign bus.resp_error    = resp_error_r;
    assign bus.ram_address   = ram_address_r;
    assign bus.ram_data_in   = ram_data_in_r;
    assign bus.ram_mem_write = ram_mem_write_r;
    assign bus.ram_mem_read  = ram_mem_read_r;

    // Request decode and the word fed to the lane aligner
    always_comb begin
        accept_s    = bus.req_valid && bus.req_ready;
        req_err_s   = req_error(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);
        is_sw_s     = bus.req_write && (bus.req_funct3 == F3_SW);
        wait_done_s = (wait_cnt_r == WAIT_LAST);
        if (state_r == ST_WAIT) begin
            align_word_s = bus.ram_data_out;
        end else begin
            align_word_s = rd_word_r;
        end
    end

    lsu_lane_align u_align (
        .word_in    (align_word_s),
        .wdata      (wdata_r),
        .addr_lo    (addr_lo_r),
        .funct3     (funct3_r),
        .load_data  (load_data_s),
        .store_word (store_word_s)
    );

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (req_err_s) begin
                        state_nxt_s = ST_RESP;
                    end else if (is_sw_s) begin
                        state_nxt_s = ST_WRITE;
                    end else begin
                        state_nxt_s = ST_READ;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ:  state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_done_s) begin
                    state_nxt_s = write_r ? ST_WRITE : ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WRITE: state_nxt_s = ST_RESP;
            ST_RESP:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request capture, RAM latency counter and the read word of a read-modify-write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_r    <= 1'b0;
            funct3_r   <= 3'b000;
            addr_lo_r  <= 2'b00;
            wdata_r    <= 32'd0;
            rd_word_r  <= 32'd0;
            wait_cnt_r <= 2'd0;
        end else begin
            if (accept_s) begin
                write_r   <= bus.req_write;
                funct3_r  <= bus.req_funct3;
                addr_lo_r <= bus.req_addr[1:0];
                wdata_r   <= bus.req_wdata;
            end
            if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + 2'd1;
            end else begin
                wait_cnt_r <= 2'd0;
            end
            if ((state_r == ST_WAIT) && wait_done_s) begin
                rd_word_r <= bus.ram_data_out;
            end
        end
    end

    // Outputs are registered from the state being entered so each strobe lives exactly one state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_r    <= 1'b0;
            resp_rdata_r    <= 32'd0;
            resp_error_r    <= 1'b0;
            ram_address_r   <= 32'd0;
            ram_data_in_r   <= 32'd0;
            ram_mem_write_r <= RAM_WRITE_IDLE;
            ram_mem_read_r  <= RAM_READ_IDLE;
        end else begin
            ram_mem_read_r  <= (state_nxt_s == ST_READ)  ? RAM_READ_WORD  : RAM_READ_IDLE;
            ram_mem_write_r <= (state_nxt_s == ST_WRITE) ? RAM_WRITE_WORD : RAM_WRITE_IDLE;
            resp_valid_r    <= (state_nxt_s == ST_RESP);
            // Only a rejected request goes straight from IDLE to RESP
            resp_error_r    <= (state_r == ST_IDLE) && (state_nxt_s == ST_RESP);
            if (accept_s && !req_err_s) begin
                ram_address_r <= {2'b00, bus.req_addr[31:2]};
            end
            if (state_nxt_s == ST_WRITE) begin
                ram_data_in_r <= (state_r == ST_IDLE) ? bus.req_wdata : store_word_s;
            end else begin
                ram_data_in_r <= 32'd0;
            end
            if ((state_r == ST_WAIT) && (state_nxt_s == ST_RESP)) begin
                resp_rdata_r <= load_data_s;
            end else begin
                resp_rdata_r <= 32'd0;
            end
        end
    end

endmodule
